// File: rtl/jtag_host_pkg.sv
// rtl/jtag_host_pkg.sv - shared types and TMS sequences for the JTAG host shifter
// Purpose: command opcodes, shifter FSM states, and the TMS header/trailer
//          patterns (bit0 is driven first) with their lengths.
// Ports: none (package).
package jtag_host_pkg;

    typedef enum logic [1:0] {
        JOP_RESET = 2'd0,
        JOP_IR    = 2'd1,
        JOP_DR    = 2'd2
    } jop_e;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_HDR,
        ST_SHIFT,
        ST_TRL,
        ST_RESP
    } st_e;

    // Run-Test/Idle -> Shift-IR: 1,1,0,0
    localparam logic [5:0] IR_HDR_TMS  = 6'b000011;
    localparam int         IR_HDR_LEN  = 4;
    // Run-Test/Idle -> Shift-DR: 1,0,0
    localparam logic [5:0] DR_HDR_TMS  = 6'b000001;
    localparam int         DR_HDR_LEN  = 3;
    // Any state -> Test-Logic-Reset -> Run-Test/Idle: 1,1,1,1,1,0
    localparam logic [5:0] RST_HDR_TMS = 6'b011111;
    localparam int         RST_HDR_LEN = 6;
    // Exit1 -> Update -> Run-Test/Idle: 1,0
    localparam logic [5:0] TRL_TMS     = 6'b000001;
    localparam int         TRL_LEN     = 2;

    function automatic logic [5:0] hdr_tms(input jop_e op);
        case (op)
            JOP_IR:  return IR_HDR_TMS;
            JOP_DR:  return DR_HDR_TMS;
            default: return RST_HDR_TMS;
        endcase
    endfunction

    function automatic int hdr_len(input jop_e op);
        case (op)
            JOP_IR:  return IR_HDR_LEN;
            JOP_DR:  return DR_HDR_LEN;
            default: return RST_HDR_LEN;
        endcase
    endfunction

endpackage

// File: rtl/jtag_tck_gen.sv
// rtl/jtag_tck_gen.sv - tck divider with one-clk rise/fall strobes
// Purpose: while en is high, tck is low DIV clks then high DIV clks, repeating.
//          tck_rise/tck_fall are high on the clk whose edge moves tck up/down.
//          While en is low tck is held low and the divider restarts.
// Ports: clk, rst (sync active-high), en; tck, tck_rise, tck_fall.
module jtag_tck_gen #(
    parameter int DIV = 2
) (
    input  logic clk,
    input  logic rst,
    input  logic en,
    output logic tck,
    output logic tck_rise,
    output logic tck_fall
);

    localparam int CNT_W = (DIV > 1) ? $clog2(DIV) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DIV - 1);

    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             tck_q, tck_d;
    logic             at_last;

    assign at_last  = (cnt_q == CNT_LAST);
    assign tck_rise = en && !tck_q && at_last;
    assign tck_fall = en &&  tck_q && at_last;
    assign tck      = tck_q;

    always_comb begin
        cnt_d = cnt_q;
        tck_d = tck_q;
        if (!en) begin
            cnt_d = '0;
            tck_d = 1'b0;
        end else if (at_last) begin
            cnt_d = '0;
            tck_d = ~tck_q;
        end else begin
            cnt_d = cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= '0;
            tck_q <= 1'b0;
        end else begin
            cnt_q <= cnt_d;
            tck_q <= tck_d;
        end
    end

endmodule

// File: rtl/jtag_host_shifter.sv
// rtl/jtag_host_shifter.sv - host-side JTAG master running TAP reset / IR / DR scans
// Purpose: accepts a scan command, walks the TAP Idle -> Shift -> Idle with a TMS
//          header, len shift bits and a TMS trailer, and returns the captured tdo.
// Ports: clk, rst (sync active-high); cmd_valid/cmd_ready/cmd_op/cmd_len/cmd_data;
//        rsp_valid/rsp_ready/rsp_data; busy; tck/tms/tdi out, tdo in;
//        trstn out only when JTAG_HOST_TRST_EN is defined.
module jtag_host_shifter
    import jtag_host_pkg::*;
#(
    parameter int MAX_LEN = 32,
    parameter int LEN_W   = $clog2(MAX_LEN + 1),
    parameter int DIV     = 2
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               cmd_valid,
    output logic               cmd_ready,
    input  logic [1:0]         cmd_op,
    input  logic [LEN_W-1:0]   cmd_len,
    input  logic [MAX_LEN-1:0] cmd_data,
    output logic               rsp_valid,
    input  logic               rsp_ready,
    output logic [MAX_LEN-1:0] rsp_data,
    output logic               busy,
    output logic               tck,
    output logic               tms,
    output logic               tdi,
`ifdef JTAG_HOST_TRST_EN
    output logic               trstn,
`endif
    input  logic               tdo
);

    st_e                state_q, state_d;
    jop_e               op_q, op_d, op_in;
    logic [LEN_W-1:0]   len_q, len_d, len_in;
    logic [LEN_W-1:0]   rem_q, rem_d;     // bits left in the current phase after this one
    logic [5:0]         pat_q, pat_d;     // TMS bits still to drive in HDR/TRL
    logic [MAX_LEN-1:0] sh_q, sh_d;       // tdi bits not yet driven
    logic [MAX_LEN-1:0] mask_q, mask_d;   // one-hot position of the current shift bit
    logic [MAX_LEN-1:0] rsp_q, rsp_d;
    logic               tms_q, tms_d;
    logic               tdi_q, tdi_d;
    logic               ready_q, ready_d;
    logic [5:0]         hdr_w;
    logic               tck_en, tck_rise, tck_fall;

    assign tck_en    = (state_q == ST_HDR) || (state_q == ST_SHIFT) || (state_q == ST_TRL);
    assign cmd_ready = ready_q;
    assign rsp_valid = (state_q == ST_RESP);
    assign rsp_data  = rsp_q;
    assign busy      = (state_q != ST_IDLE);
    assign tms       = tms_q;
    assign tdi       = tdi_q;

    jtag_tck_gen #(.DIV(DIV)) u_tck_gen (
        .clk      (clk),
        .rst      (rst),
        .en       (tck_en),
        .tck      (tck),
        .tck_rise (tck_rise),
        .tck_fall (tck_fall)
    );

    always_comb begin
        case (cmd_op)
            2'd1:    op_in = JOP_IR;
            2'd2:    op_in = JOP_DR;
            default: op_in = JOP_RESET;
        endcase
        len_in = (cmd_len > LEN_W'(MAX_LEN)) ? LEN_W'(MAX_LEN) : cmd_len;
        hdr_w  = hdr_tms(op_in);
    end

    // New tms/tdi values are loaded on the tck falling strobe so they are set up
    // for the whole low half; tdo is captured on the rising strobe.
    always_comb begin
        state_d = state_q;
        op_d    = op_q;
        len_d   = len_q;
        rem_d   = rem_q;
        pat_d   = pat_q;
        sh_d    = sh_q;
        mask_d  = mask_q;
        rsp_d   = rsp_q;
        tms_d   = tms_q;
        tdi_d   = tdi_q;
        case (state_q)
            ST_IDLE: begin
                if (cmd_valid && ready_q) begin
                    op_d   = op_in;
                    len_d  = len_in;
                    sh_d   = cmd_data;
                    mask_d = MAX_LEN'(1);
                    rsp_d  = '0;
                    tdi_d  = 1'b0;
                    if (op_in != JOP_RESET && len_in == '0) begin
                        state_d = ST_RESP;
                        tms_d   = 1'b0;
                    end else begin
                        state_d = ST_HDR;
                        tms_d   = hdr_w[0];
                        pat_d   = hdr_w >> 1;
                        rem_d   = LEN_W'(hdr_len(op_in) - 1);
                    end
                end
            end
            ST_HDR: begin
                if (tck_fall) begin
                    if (rem_q != '0) begin
                        tms_d = pat_q[0];
                        pat_d = pat_q >> 1;
                        rem_d = rem_q - LEN_W'(1);
                    end else if (op_q == JOP_RESET) begin
                        state_d = ST_RESP;
                        tms_d   = 1'b0;
                    end else begin
                        state_d = ST_SHIFT;
                        rem_d   = len_q - LEN_W'(1);
                        tms_d   = (len_q == LEN_W'(1));
                        tdi_d   = sh_q[0];
                        sh_d    = sh_q >> 1;
                    end
                end
            end
            ST_SHIFT: begin
                if (tck_rise && tdo) begin
                    rsp_d = rsp_q | mask_q;
                end
                if (tck_fall) begin
                    mask_d = mask_q << 1;
                    if (rem_q == '0) begin
                        state_d = ST_TRL;
                        tms_d   = TRL_TMS[0];
                        pat_d   = TRL_TMS >> 1;
                        rem_d   = LEN_W'(TRL_LEN - 1);
                        tdi_d   = 1'b0;
                    end else begin
                        rem_d = rem_q - LEN_W'(1);
                        tms_d = (rem_q == LEN_W'(1));  // last bit moves to Exit1
                        tdi_d = sh_q[0];
                        sh_d  = sh_q >> 1;
                    end
                end
            end
            ST_TRL: begin
                if (tck_fall) begin
                    if (rem_q != '0) begin
                        tms_d = pat_q[0];
                        pat_d = pat_q >> 1;
                        rem_d = rem_q - LEN_W'(1);
                    end else begin
                        state_d = ST_RESP;
                        tms_d   = 1'b0;
                    end
                end
            end
            ST_RESP: begin
                if (rsp_ready) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
        // Registered so cmd_ready stays low for the cycle right after reset.
        ready_d = (state_d == ST_IDLE);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
            op_q    <= JOP_RESET;
            len_q   <= '0;
            rem_q   <= '0;
            pat_q   <= '0;
            sh_q    <= '0;
            mask_q  <= '0;
            rsp_q   <= '0;
            tms_q   <= 1'b1;
            tdi_q   <= 1'b0;
            ready_q <= 1'b0;
        end else begin
            state_q <= state_d;
            op_q    <= op_d;
            len_q   <= len_d;
            rem_q   <= rem_d;
            pat_q   <= pat_d;
            sh_q    <= sh_d;
            mask_q  <= mask_d;
            rsp_q   <= rsp_d;
            tms_q   <= tms_d;
            tdi_q   <= tdi_d;
            ready_q <= ready_d;
        end
    end

`ifdef JTAG_HOST_TRST_EN
    // trstn is held low for the whole TAP-reset command, response phase included.
    logic trstn_q, trstn_d;

    always_comb begin
        trstn_d = !((state_d != ST_IDLE) && (op_d == JOP_RESET));
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            trstn_q <= 1'b0;
        end else begin
            trstn_q <= trstn_d;
        end
    end

    assign trstn = trstn_q && !rst;
`endif

endmodule

// File: tb/tb_jtag_host_shifter.sv
// tb/tb_jtag_host_shifter.sv - directed bench for jtag_host_shifter against a TAP model
module tb_jtag_host_shifter;

    localparam int MAX_LEN = 32;
    localparam int LEN_W   = 6;
    localparam logic [3:0]  IDC_INSN = 4'b0010;
    localparam logic [31:0] IDCODE   = 32'h4BA0_0477;

    logic               clk = 1'b0;
    logic               rst = 1'b1;
    logic               cmd_valid = 1'b0;
    logic               cmd_ready;
    logic [1:0]         cmd_op = 2'd0;
    logic [LEN_W-1:0]   cmd_len = '0;
    logic [MAX_LEN-1:0] cmd_data = '0;
    logic               rsp_valid;
    logic               rsp_ready = 1'b0;
    logic [MAX_LEN-1:0] rsp_data;
    logic               busy;
    logic               tck;
    logic               tms;
    logic               tdi;
    logic               tdo = 1'b0;
`ifdef JTAG_HOST_TRST_EN
    logic               trstn;
`endif

    int n_chk = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    jtag_host_shifter #(.MAX_LEN(MAX_LEN), .LEN_W(LEN_W), .DIV(2)) dut (
        .clk       (clk),
        .rst       (rst),
        .cmd_valid (cmd_valid),
        .cmd_ready (cmd_ready),
        .cmd_op    (cmd_op),
        .cmd_len   (cmd_len),
        .cmd_data  (cmd_data),
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .rsp_data  (rsp_data),
        .busy      (busy),
        .tck       (tck),
        .tms       (tms),
        .tdi       (tdi),
`ifdef JTAG_HOST_TRST_EN
        .trstn     (trstn),
`endif
        .tdo       (tdo)
    );

    typedef enum logic [3:0] {
        T_TLR, T_RTI, T_SDR, T_CDR, T_SHD, T_E1D, T_PDR, T_E2D,
        T_UDR, T_SIR, T_CIR, T_SHI, T_E1I, T_PIR, T_E2I, T_UIR
    } tap_e;

    function automatic tap_e tap_next(input tap_e s, input logic m);
        case (s)
            T_TLR:   return m ? T_TLR : T_RTI;
            T_RTI:   return m ? T_SDR : T_RTI;
            T_SDR:   return m ? T_SIR : T_CDR;
            T_CDR:   return m ? T_E1D : T_SHD;
            T_SHD:   return m ? T_E1D : T_SHD;
            T_E1D:   return m ? T_UDR : T_PDR;
            T_PDR:   return m ? T_E2D : T_PDR;
            T_E2D:   return m ? T_UDR : T_SHD;
            T_UDR:   return m ? T_SDR : T_RTI;
            T_SIR:   return m ? T_TLR : T_CIR;
            T_CIR:   return m ? T_E1I : T_SHI;
            T_SHI:   return m ? T_E1I : T_SHI;
            T_E1I:   return m ? T_UIR : T_PIR;
            T_PIR:   return m ? T_E2I : T_PIR;
            T_E2I:   return m ? T_UIR : T_SHI;
            default: return m ? T_SDR : T_RTI;
        endcase
    endfunction

    tap_e        tap_st  = T_TLR;
    logic [3:0]  ir      = IDC_INSN;
    logic [3:0]  ir_sh   = 4'b0;
    logic [31:0] dr_sh   = 32'b0;
    logic        byp     = 1'b0;
    int          tck_cnt = 0;
    logic [63:0] tms_log = 64'b0;

    always @(posedge tck) begin
        case (tap_st)
            T_TLR: ir <= IDC_INSN;
            T_CIR: ir_sh <= 4'b0101;
            T_SHI: ir_sh <= {tdi, ir_sh[3:1]};
            T_UIR: ir <= ir_sh;
            T_CDR: begin dr_sh <= IDCODE; byp <= 1'b0; end
            T_SHD: begin dr_sh <= {tdi, dr_sh[31:1]}; byp <= tdi; end
            default: ;
        endcase
        tap_st  <= tap_next(tap_st, tms);
        tck_cnt <= tck_cnt + 1;
        tms_log <= {tms_log[62:0], tms};
    end

    always @(negedge tck) begin
        if (tap_st == T_SHI)      tdo <= ir_sh[0];
        else if (tap_st == T_SHD) tdo <= (ir == IDC_INSN) ? dr_sh[0] : byp;
        else                      tdo <= 1'b0;
    end

    task automatic expect_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic send(input logic [1:0] op, input logic [LEN_W-1:0] len, input logic [31:0] data);
        int n;
        n = 0;
        while (cmd_ready !== 1'b1 && n < 50) begin
            @(negedge clk);
            n++;
        end
        expect_eq("cmd_ready_wait", 64'(n < 50), 1);
        cmd_op    = op;
        cmd_len   = len;
        cmd_data  = data;
        cmd_valid = 1'b1;
        @(negedge clk);
        cmd_valid = 1'b0;
    endtask

    task automatic get_rsp(input string tag, input logic [31:0] exp, input bit op0,
                           input int hold, output int lat);
`ifdef JTAG_HOST_TRST_EN
        int trst_hi;
        trst_hi = 0;
`endif
        lat = 0;
        while (rsp_valid !== 1'b1 && lat < 400) begin
`ifdef JTAG_HOST_TRST_EN
            if (op0 && trstn !== 1'b0) trst_hi++;
`endif
            @(negedge clk);
            lat++;
        end
        expect_eq({tag, "_rsp_seen"}, 64'(lat < 400), 1);
        expect_eq({tag, "_data"}, rsp_data, exp);
        if (op0) expect_eq({tag, "_tap_idle"}, 64'(tap_st == T_RTI), 1);
        for (int i = 0; i < hold; i++) begin
            @(negedge clk);
            expect_eq({tag, "_hold_valid"}, rsp_valid, 1);
            expect_eq({tag, "_hold_data"}, rsp_data, exp);
            expect_eq({tag, "_hold_ready"}, cmd_ready, 0);
            expect_eq({tag, "_hold_tck"}, tck, 0);
        end
`ifdef JTAG_HOST_TRST_EN
        if (op0) begin
            if (trstn !== 1'b0) trst_hi++;
            expect_eq({tag, "_trstn_low"}, trst_hi, 0);
        end
`endif
        rsp_ready = 1'b1;
        @(negedge clk);
        rsp_ready = 1'b0;
        expect_eq({tag, "_valid_drop"}, rsp_valid, 0);
        expect_eq({tag, "_busy_drop"}, busy, 0);
        expect_eq({tag, "_tms_park"}, tms, 0);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        int c0;
        int lat;
        int n;

        repeat (2) @(negedge clk);
        expect_eq("rst_tck", tck, 0);
        expect_eq("rst_tms", tms, 1);
        expect_eq("rst_tdi", tdi, 0);
        expect_eq("rst_ready", cmd_ready, 0);
        expect_eq("rst_rsp_valid", rsp_valid, 0);
        expect_eq("rst_rsp_data", rsp_data, 0);
        expect_eq("rst_busy", busy, 0);
`ifdef JTAG_HOST_TRST_EN
        expect_eq("rst_trstn", trstn, 0);
`endif
        rst = 1'b0;
        @(negedge clk);
        expect_eq("post_rst_ready", cmd_ready, 1);

        // TAP reset
        c0 = tck_cnt;
        send(2'd0, 6'd0, 32'h0);
        get_rsp("op0", 32'h0, 1'b1, 0, lat);
        expect_eq("op0_tck", tck_cnt - c0, 6);
        expect_eq("op0_tms_seq", tms_log[5:0], 6'b111110);

        // IR scan loading IDCODE instruction
        c0 = tck_cnt;
        send(2'd1, 6'd4, 32'h2);
        get_rsp("ir4", 32'h5, 1'b0, 0, lat);
        expect_eq("ir4_tck", tck_cnt - c0, 10);
        expect_eq("ir4_tms_seq", tms_log[9:0], 10'b1100000110);
        expect_eq("ir4_latched", ir, 4'b0010);
        expect_eq("ir4_tap_idle", 64'(tap_st == T_RTI), 1);

        // 32-bit DR scan reads IDCODE
        c0 = tck_cnt;
        send(2'd2, 6'd32, 32'hDEAD_BEEF);
        get_rsp("dr32", IDCODE, 1'b0, 0, lat);
        expect_eq("dr32_tck", tck_cnt - c0, 37);
        expect_eq("dr32_tap_idle", 64'(tap_st == T_RTI), 1);

        // zero-length scan: no tck, response one clk after accept
        c0 = tck_cnt;
        send(2'd2, 6'd0, 32'hFFFF_FFFF);
        get_rsp("dr0", 32'h0, 1'b0, 0, lat);
        expect_eq("dr0_latency", lat, 0);
        expect_eq("dr0_tck", tck_cnt - c0, 0);

        // response held while rsp_ready stays low
        c0 = tck_cnt;
        send(2'd2, 6'd8, 32'hA5);
        get_rsp("hold", 32'h77, 1'b0, 20, lat);
        expect_eq("hold_tck_cnt", tck_cnt - c0, 13);

        // length above MAX_LEN clamps to MAX_LEN
        c0 = tck_cnt;
        send(2'd2, 6'd40, 32'h0);
        get_rsp("clamp", IDCODE, 1'b0, 0, lat);
        expect_eq("clamp_tck", tck_cnt - c0, 37);

        // BYPASS: one-bit register delays tdi by one shift
        send(2'd1, 6'd4, 32'hF);
        get_rsp("ir_byp", 32'h5, 1'b0, 0, lat);
        expect_eq("ir_byp_latched", ir, 4'b1111);
        c0 = tck_cnt;
        send(2'd2, 6'd4, 32'hB);
        get_rsp("byp4", 32'h6, 1'b0, 0, lat);
        expect_eq("byp4_tck", tck_cnt - c0, 9);

        // reserved opcode behaves as TAP reset
        c0 = tck_cnt;
        send(2'd3, 6'd12, 32'h0);
        get_rsp("op3", 32'h0, 1'b1, 0, lat);
        expect_eq("op3_tck", tck_cnt - c0, 6);
        expect_eq("op3_ir_reset", ir, IDC_INSN);

        // reset during shift bit 7 of a 16-bit DR scan
        c0 = tck_cnt;
        send(2'd2, 6'd16, 32'h0000_BEEF);
        n = 0;
        while (tck_cnt - c0 < 11 && n < 400) begin
            @(negedge clk);
            n++;
        end
        expect_eq("midrst_reach", 64'(n < 400), 1);
        rst = 1'b1;
        @(negedge clk);
        expect_eq("midrst_tck", tck, 0);
        expect_eq("midrst_tms", tms, 1);
        expect_eq("midrst_busy", busy, 0);
`ifdef JTAG_HOST_TRST_EN
        expect_eq("midrst_trstn", trstn, 0);
`endif
        rst = 1'b0;
        @(negedge clk);
        send(2'd0, 6'd0, 32'h0);
        get_rsp("rec_op0", 32'h0, 1'b1, 0, lat);
        send(2'd2, 6'd32, 32'h1234_5678);
        get_rsp("rec_dr32", IDCODE, 1'b0, 0, lat);

        $display("test done: total=%0d bad=%0d", n_chk, n_bad);
        $finish;
    end

endmodule
